scarv_cop_pmul_iter: RTL and testbench

Parametrised, iterative packed multiplier for the coprocessor packed-arithmetic class. It computes lane-wise unsigned or carry-less products over 1 to 16 lanes, returning either the low or the high half of each lane's double-width product. The datapath width and the number of multiplier bits retired per cycle are generic. It sits behind the PALU issue logic and uses a valid/ready handshake on both sides, so results can be back-pressured.

---
 rtl/scarv_cop_pmul_iter.sv | 180 ++++++++++++++++++
 tb/tb_scarv_cop_pmul_iter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_pmul_iter.sv
// Iterative packed multiplier: lane-wise unsigned or carry-less products over
// 1..16 lanes, returning the low or high half of each lane product. Retires
// BPC multiplier bits per lane per cycle behind a valid/ready handshake.
//
// Datapath idea: lane products are kept in a "spread" 2*XLEN accumulator in
// which lane i owns bits [2*LW*i +: 2*LW]. Because a lane's partial sum never
// exceeds its final 2*LW-bit product, one full-width add (or XOR) per partial
// product and one full-width shift of the spread multiplicand never leak bits
// across lane boundaries. Only the per-lane multiplier-bit masks and the
// spread/gather networks depend on the pack width.
module scarv_cop_pmul_iter #(
  parameter int XLEN = 32,
  parameter int BPC  = 4
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [2:0]      in_pw,
  input  logic            in_high,
  input  logic            in_ncarry,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_err
);

  localparam int AW = 2 * XLEN;
  // Step count never exceeds XLEN (one lane, BPC=1).
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      cfg_reg;
  logic            err_reg;
  logic            high_reg;
  logic            ncarry_reg;
  logic [AW-1:0]   a_reg;
  logic [AW-1:0]   acc_reg;
  logic [XLEN-1:0] b_reg;
  logic [CW-1:0]   cnt_reg;

  // Per-configuration networks, indexed by lane configuration (pw - 1).
  logic [AW-1:0]          spread_all [8];
  logic [XLEN-1:0]        lo_all     [8];
  logic [XLEN-1:0]        hi_all     [8];
  logic [BPC-1:0][AW-1:0] mask_all   [8];
  logic [CW-1:0]          n_all      [8];

  logic          pw_legal;
  logic [2:0]    pw_cfg;
  logic          accept;
  logic [AW-1:0] acc_step;
  logic [AW-1:0] part;

  assign pw_legal = (in_pw >= 3'd1) && (in_pw <= 3'd5);
  assign pw_cfg   = in_pw - 3'd1;
  assign in_ready = (state_reg == S_IDLE) && !flush;
  assign accept   = in_valid && in_ready;

  for (genvar gi = 0; gi < 8; gi++) begin : g_cfg
    if (gi < 5) begin : g_lane
      localparam int NL = 1 << gi;
      localparam int LW = XLEN / NL;
      localparam int NS = (LW > BPC) ? (LW / BPC) : 1;

      logic [AW-1:0]          spread;
      logic [XLEN-1:0]        lo;
      logic [XLEN-1:0]        hi;
      logic [BPC-1:0][AW-1:0] mask;

      // Spread operand, lane multiplier-bit masks and lo/hi gather for this lane count.
      always_comb begin
        spread = '0;
        lo     = '0;
        hi     = '0;
        mask   = '0;
        for (int li = 0; li < NL; li++) begin
          spread[2*LW*li +: LW] = in_a[LW*li +: LW];
          lo[LW*li +: LW]       = acc_reg[2*LW*li +: LW];
          hi[LW*li +: LW]       = acc_reg[2*LW*li + LW +: LW];
          for (int j = 0; j < BPC; j++) begin
            // Lanes narrower than BPC only own LW multiplier bits.
            if (j < LW) begin
              mask[j][2*LW*li +: 2*LW] = {(2*LW){b_reg[LW*li + j]}};
            end
          end
        end
      end

      assign spread_all[gi] = spread;
      assign lo_all[gi]     = lo;
      assign hi_all[gi]     = hi;
      assign mask_all[gi]   = mask;
      assign n_all[gi]      = CW'(NS);
    end else begin : g_none
      assign spread_all[gi] = '0;
      assign lo_all[gi]     = '0;
      assign hi_all[gi]     = '0;
      assign mask_all[gi]   = '0;
      assign n_all[gi]      = CW'(1);
    end
  end

  // One iteration: fold BPC masked, shifted multiplicands into the accumulator.
  always_comb begin
    acc_step = acc_reg;
    part     = '0;
    for (int j = 0; j < BPC; j++) begin
      part = (a_reg << j) & mask_all[cfg_reg][j];
      if (ncarry_reg) begin
        acc_step = acc_step ^ part;
      end else begin
        acc_step = acc_step + part;
      end
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (in_valid)              state_next = S_BUSY;
      S_BUSY:  if (cnt_reg == CW'(1))     state_next = S_DONE;
      S_DONE:  if (out_ready)             state_next = S_IDLE;
      default:                            state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next = S_IDLE;
    end
  end

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand latch on accept, then one multiply step per BUSY cycle.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      cfg_reg    <= '0;
      err_reg    <= 1'b0;
      high_reg   <= 1'b0;
      ncarry_reg <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (accept) begin
      // Illegal pack widths run a single empty step and report an error.
      cfg_reg    <= pw_legal ? pw_cfg : 3'd0;
      err_reg    <= !pw_legal;
      high_reg   <= in_high;
      ncarry_reg <= in_ncarry;
      a_reg      <= pw_legal ? spread_all[pw_cfg] : '0;
      b_reg      <= pw_legal ? in_b : '0;
      acc_reg    <= '0;
      cnt_reg    <= pw_legal ? n_all[pw_cfg] : CW'(1);
    end else if (state_reg == S_BUSY) begin
      acc_reg <= acc_step;
      a_reg   <= a_reg << BPC;
      b_reg   <= b_reg >> BPC;
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign out_valid  = (state_reg == S_DONE);
  assign out_err    = out_valid && err_reg;
  assign out_result = (out_valid && !err_reg) ?
                      (high_reg ? hi_all[cfg_reg] : lo_all[cfg_reg]) : '0;

endmodule

// File: tb/tb_scarv_cop_pmul_iter.sv
// Self-checking bench for scarv_cop_pmul_iter (XLEN=32, BPC=4): a lane-wise
// arithmetic model predicts every output each cycle; directed vectors with
// hand-computed results pin both the model and the DUT.
module tb_scarv_cop_pmul_iter;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [2:0]  in_pw = 3'd1;
  logic        in_high = 1'b0;
  logic        in_ncarry = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_err;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 g_clk = ~g_clk;

  scarv_cop_pmul_iter #(.XLEN(32), .BPC(4)) dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_pw      (in_pw),
    .in_high    (in_high),
    .in_ncarry  (in_ncarry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Lane-wise reference product straight from the arithmetic definition.
  function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [2:0] pw, input logic h, input logic nc);
    int lanes;
    int lw;
    longint unsigned x, y, p, m, lane;
    logic [31:0] r;
    r = '0;
    if (pw == 3'd0 || pw > 3'd5) return r;
    lanes = 1 << (pw - 3'd1);
    lw    = 32 / lanes;
    m     = (64'd1 << lw) - 64'd1;
    for (int i = 0; i < lanes; i++) begin
      x = (64'(a) >> (i * lw)) & m;
      y = (64'(b) >> (i * lw)) & m;
      if (nc) begin
        p = 0;
        for (int k = 0; k < lw; k++) if (y[k]) p = p ^ (x << k);
      end else begin
        p = x * y;
      end
      lane = h ? ((p >> lw) & m) : (p & m);
      r = r | 32'(lane << (i * lw));
    end
    return r;
  endfunction

  function automatic int model_n(input logic [2:0] pw);
    int lw;
    if (pw == 3'd0 || pw > 3'd5) return 1;
    lw = 32 >> (pw - 3'd1);
    return (lw / 4 > 1) ? lw / 4 : 1;
  endfunction

  // Reference timing: 0 = waiting for request, 1 = computing, 2 = result offered.
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [31:0] m_res = '0;
  logic        m_err = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [2:0]  m_pw = '0;

  always @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      m_phase <= 0;
      m_cnt   <= 0;
    end else if (flush) begin
      if (m_phase == 2 && out_ready)
        $display("txn dropped by flush a=%h b=%h pw=%0d", m_a, m_b, m_pw);
      m_phase <= 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_res   <= model_result(in_a, in_b, in_pw, in_high, in_ncarry);
          m_err   <= (in_pw == 3'd0 || in_pw > 3'd5);
          m_cnt   <= model_n(in_pw);
          m_a     <= in_a;
          m_b     <= in_b;
          m_pw    <= in_pw;
          m_phase <= 1;
        end
        1: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) m_phase <= 2;
        end
        default: if (out_ready) begin
          $display("txn a=%h b=%h pw=%0d result=%h err=%0d", m_a, m_b, m_pw, m_res, m_err);
          m_phase <= 0;
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison against the reference.
  always @(negedge g_clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, (m_phase == 0) && !flush);
      check("out_valid", out_valid, m_phase == 2);
      check("out_result", out_result, (m_phase == 2 && !m_err) ? m_res : 32'h0);
      check("out_err", out_err, (m_phase == 2) && m_err);
    end
  end

  // Waits (bounded) for out_valid; returns edges counted after the accept edge.
  task automatic wait_valid(output int k, output bit seen);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(posedge g_clk);
      k++;
      @(negedge g_clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_valid: got no out_valid expected one within 100 edges");
    end
  endtask

  // One full operation with out_ready high; starts and ends at posedge+1 in IDLE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] pw,
                        input logic h, input logic nc, input logic [31:0] lit,
                        input bit use_lit, input int lit_n, input logic lit_err);
    int k;
    bit seen;
    in_a = a; in_b = b; in_pw = pw; in_high = h; in_ncarry = nc;
    in_valid = 1'b1; out_ready = 1'b1;
    if (use_lit) check("model_pin", model_result(a, b, pw, h, nc), lit);
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    // Inputs wander while busy; they must be ignored.
    in_a = ~a; in_b = $urandom; in_pw = pw + 3'd1; in_high = ~h; in_ncarry = ~nc;
    wait_valid(k, seen);
    if (seen) begin
      if (lit_n > 0) check("latency", k, lit_n);
      if (use_lit) check("result_lit", out_result, lit);
      check("err_lit", out_err, lit_err);
    end
    @(posedge g_clk); #1;
  endtask

  logic [31:0] ops_a [3] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF};
  logic [31:0] ops_b [3] = '{32'h8765_4321, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  int          n_tab [8] = '{1, 8, 4, 2, 1, 1, 1, 1};

  initial begin
    int k;
    bit seen;
    logic [31:0] held;

    #1 g_resetn = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge g_clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_err", out_err, 1'b0);
    @(posedge g_clk); #1 g_resetn = 1'b1;

    // Directed vectors with hand-computed results.
    run_op(32'h0001_0000, 32'h0001_0000, 3'b001, 1'b0, 1'b0, 32'h0000_0000, 1, 8, 1'b0);
    run_op(32'h0001_0000, 32'h0001_0000, 3'b001, 1'b1, 1'b0, 32'h0000_0001, 1, 8, 1'b0);
    run_op(32'hFF02_0310, 32'hFF03_0410, 3'b011, 1'b0, 1'b0, 32'h0106_0C00, 1, 2, 1'b0);
    run_op(32'hFF02_0310, 32'hFF03_0410, 3'b011, 1'b1, 1'b0, 32'hFE00_0001, 1, 2, 1'b0);
    run_op(32'h0000_0003, 32'h0000_0003, 3'b001, 1'b0, 1'b1, 32'h0000_0005, 1, 8, 1'b0);
    run_op(32'h0000_0003, 32'h0000_0003, 3'b001, 1'b0, 1'b0, 32'h0000_0009, 1, 8, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b001, 1'b1, 1'b0, 32'hFFFF_FFFE, 1, 8, 1'b0);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 3'b010, 1'b0, 1'b0, 32'hA630_2080, 1, 4, 1'b0);
    run_op(32'hCAFE_F00D, 32'h1357_9BDF, 3'b111, 1'b0, 1'b0, 32'h0000_0000, 1, 1, 1'b1);

    // Sweep of pack widths and modes checked by the reference model.
    for (int pw = 0; pw < 8; pw++)
      for (int h = 0; h < 2; h++)
        for (int nc = 0; nc < 2; nc++)
          for (int v = 0; v < 3; v++)
            run_op(ops_a[v], ops_b[v], 3'(pw), 1'(h), 1'(nc), 32'h0, 0, n_tab[pw],
                   (pw == 0 || pw > 5));

    // Back-pressure: result held in DONE while inputs change and in_valid stays high.
    in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0; in_pw = 3'b010;
    in_high = 1'b0; in_ncarry = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge g_clk); #1;
    in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_pw = 3'b001;
    wait_valid(k, seen);
    held = out_result;
    check("bp_result", held, 32'hA630_2080);
    repeat (5) begin
      @(posedge g_clk); #1;
      in_a = $urandom; in_b = $urandom;
      @(negedge g_clk);
      check("bp_stable", out_result, held);
      check("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge g_clk); #1;
    in_a = 32'h3; in_b = 32'h3; in_pw = 3'b001; in_ncarry = 1'b1; out_ready = 1'b1;
    @(posedge g_clk); #1;
    check("bp_reaccept_ready", in_ready, 1'b1);
    @(posedge g_clk); #1;
    in_valid = 1'b0;
    wait_valid(k, seen);
    if (seen) begin
      check("bp_next_latency", k, 8);
      check("bp_next_result", out_result, 32'h5);
    end
    @(posedge g_clk); #1;

    // Flush on the third BUSY cycle.
    in_a = 32'hABCD_1234; in_b = 32'h5678_9ABC; in_pw = 3'b001; in_ncarry = 1'b0;
    in_valid = 1'b1;
    @(posedge g_clk); #1 in_valid = 1'b0;
    @(posedge g_clk);
    @(posedge g_clk); #1 flush = 1'b1;
    @(posedge g_clk); #1 flush = 1'b0;
    @(negedge g_clk);
    check("flush_idle", in_ready, 1'b1);
    repeat (12) begin
      @(negedge g_clk);
      check("flush_no_valid", out_valid, 1'b0);
    end
    @(posedge g_clk); #1;

    // Flush wins over out_ready in DONE.
    in_pw = 3'b100; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge g_clk); #1 in_valid = 1'b0;
    wait_valid(k, seen);
    @(posedge g_clk); #1 flush = 1'b1; out_ready = 1'b1;
    @(posedge g_clk); #1 flush = 1'b0;
    @(negedge g_clk);
    check("flush_done_drop", out_valid, 1'b0);
    @(posedge g_clk); #1;

    // Reset mid-BUSY, then a clean operation.
    in_pw = 3'b001; in_valid = 1'b1;
    @(posedge g_clk); #1 in_valid = 1'b0;
    @(posedge g_clk);
    @(posedge g_clk); #1 g_resetn = 1'b0;
    #1;
    check("rst_busy_in_ready", in_ready, 1'b1);
    check("rst_busy_out_valid", out_valid, 1'b0);
    @(posedge g_clk); #1 g_resetn = 1'b1;
    run_op(32'h0000_0003, 32'h0000_0003, 3'b001, 1'b0, 1'b0, 32'h0000_0009, 1, 8, 1'b0);

    // Reset while a result is offered clears the outputs at once.
    in_a = 32'hFFFF_FFFF; in_b = 32'hAAAA_AAAA; in_pw = 3'b101; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge g_clk); #1 in_valid = 1'b0;
    wait_valid(k, seen);
    #1 g_resetn = 1'b0;
    #1;
    check("rst_done_out_valid", out_valid, 1'b0);
    check("rst_done_out_result", out_result, 32'h0);
    @(posedge g_clk); #1 g_resetn = 1'b1;
    run_op(32'hFF02_0310, 32'hFF03_0410, 3'b011, 1'b1, 1'b0, 32'hFE00_0001, 1, 2, 1'b0);

    repeat (2) @(posedge g_clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before t=500000");
    $fatal(1, "watchdog expired");
  end

endmodule
